rd32_stream_arbiter: RTL and testbench
======================================

RD32_STREAM_ARBITER -- requirements
Module: rd32_stream_arbiter

Interface
REQ-001 SHALL have parameter BURST, default 16: maximum payload words per granted burst (legal 1..255).
REQ-002 SHALL have parameter HDR_MAGIC, default 8'hA5: header word bits [31:24].
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 bus_clk  input  1  sole clock, all logic on rising edge.
REQ-005 bus_rst  input  1  asynchronous active-high reset.
REQ-006 src0_data / src1_data  input  32  source FIFO read data, valid the cycle after the matching rden.
REQ-007 src0_count / src1_count  input  16  words currently readable in each source FIFO.
REQ-008 src0_eof / src1_eof  input  1  source will produce no further data.
REQ-009 src0_rden / src1_rden  output  1  single-cycle source read strobe.
REQ-010 user_r_read_32_open  input  1  host has the read_32 device file open.
REQ-011 user_r_read_32_rden  input  1  host read strobe.
REQ-012 user_r_read_32_data  output  32  word delivered to host.
REQ-013 user_r_read_32_empty  output  1  no word available to host.
REQ-014 user_r_read_32_eof  output  1  end of stream to host.

Function
REQ-015 Host side SHALL be standard-FIFO: on rden with empty low, user_r_read_32_data SHALL update at the next edge with the staged word; rden while empty SHALL be ignored.
REQ-016 One staging register (stg, stg_valid) SHALL hold the next host word; empty = !stg_valid; a host read SHALL clear stg_valid.
REQ-017 FSM states SHALL be IDLE, HDR, FETCH, WAIT.
REQ-018 IDLE: if open high and some srcN_count > 0, grant round-robin (source not granted last wins ties; src0 wins after reset), latch len = min(count, BURST), latch id, go HDR.
REQ-019 HDR: when !stg_valid, load stg = {HDR_MAGIC, 7'b0, id, len[15:0]}, set stg_valid, go FETCH.
REQ-020 FETCH: when !stg_valid, pulse granted srcN_rden for exactly one cycle, go WAIT.
REQ-021 WAIT: capture srcN_data into stg, set stg_valid, decrement remaining; remaining reaching 0 -> IDLE, else FETCH.
REQ-022 At most one of src0_rden/src1_rden SHALL be high in any cycle; rden SHALL never be issued to the non-granted source.
REQ-023 Burst length SHALL be fixed at grant; count changes during a burst SHALL be ignored.
REQ-024 Peak throughput SHALL be one payload word per host read plus the FETCH/WAIT latency; header costs one slot per burst.
REQ-025 user_r_read_32_eof SHALL be high iff src0_eof and src1_eof high, state IDLE, both counts 0 and !stg_valid.
REQ-026 open low SHALL force state IDLE and clear stg_valid at the next edge; a WAIT-cycle source word in flight SHALL be discarded; rr pointer SHALL be kept.
REQ-027 Simultaneous host read and stg load SHALL not occur (load only when !stg_valid); load after read in the same cycle is deferred one cycle.

Reset
REQ-028 On bus_rst: state IDLE, stg_valid 0, stg 0, user_r_read_32_data 0, src0_rden/src1_rden 0, rr pointer favouring src0, remaining 0.
REQ-029 Reset outputs: user_r_read_32_empty 1, user_r_read_32_eof 0 (computed, eof inputs low).
REQ-030 Reset asserted mid-burst SHALL abandon the burst with no further rden pulses.

Structure
REQ-031 Shared package SHALL hold FSM state enum, header field positions and default HDR_MAGIC.
REQ-032 Round-robin choice SHALL be a sub-module rd32_rr_pick2 (two requests, last-grant input, one-hot grant out).

Verification
REQ-033 src0_count=3, src1_count=0, open high, host reads continuously -> host receives 32'hA500_0003 then 3 src0 words in order, then empty.
REQ-034 both counts=40, BURST=16 -> headers alternate A500_0010 (src0), A501_0010 (src1), src0 first after reset.
REQ-035 host rden held high while empty -> no data change, no source rden.
REQ-036 open dropped during WAIT of burst len 5 -> next cycle IDLE, empty 1, no further rden; reopen -> new header issued.
REQ-037 both eof high, counts 0, stg drained -> user_r_read_32_eof 1; any count nonzero -> eof 0.
REQ-038 bus_rst pulsed mid-burst -> all outputs at REQ-028/029 values within same cycle, no rden afterwards until new grant.

Source files
------------

// File: rtl/rd32_stream_arbiter_pkg.sv
// Shared types and constants for the two-source read_32 stream arbiter.
package rd32_stream_arbiter_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HDR   = 2'd1,
        ST_FETCH = 2'd2,
        ST_WAIT  = 2'd3
    } arb_state_e;

    // Header word layout: {magic[31:24], zero[23:17], id[16], len[15:0]}
    localparam logic [7:0] HDR_MAGIC_DEFAULT = 8'hA5;
    localparam int         HDR_MAGIC_LSB     = 24;
    localparam int         HDR_ID_BIT        = 16;
    localparam int         HDR_LEN_LSB       = 0;
    localparam int         HDR_LEN_W         = 16;

    // Assemble a burst header word
    function automatic logic [31:0] make_hdr(input logic [7:0]  magic,
                                             input logic        id,
                                             input logic [15:0] len);
        logic [31:0] w;
        w = '0;
        w[HDR_MAGIC_LSB +: 8]         = magic;
        w[HDR_ID_BIT]                 = id;
        w[HDR_LEN_LSB +: HDR_LEN_W]   = len;
        return w;
    endfunction

endpackage

// File: rtl/rd32_rr_pick2.sv
// Two-way round-robin pick: on a tie the source not granted last wins.
module rd32_rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    // One-hot grant; last_i = 1 means src1 was granted last, so src0 wins ties
    always_comb begin
        gnt_o = 2'b00;
        if (req_i == 2'b11) begin
            gnt_o = last_i ? 2'b01 : 2'b10;
        end else begin
            gnt_o = req_i;
        end
    end

endmodule

// File: rtl/rd32_stream_arbiter.sv
// Merges two source FIFOs into one host read_32 stream as headered bursts.
// Handshake: host side is a standard FIFO -- a word is consumed on the
// rising edge where user_r_read_32_rden is high and user_r_read_32_empty is
// low; rden while empty is ignored. Source side: srcN_rden is a one-cycle
// strobe and srcN_data is valid in the following cycle.
module rd32_stream_arbiter
    import rd32_stream_arbiter_pkg::*;
#(
    parameter int         BURST     = 16,
    parameter logic [7:0] HDR_MAGIC = HDR_MAGIC_DEFAULT
) (
    input  logic        bus_clk,
    input  logic        bus_rst,
    input  logic [31:0] src0_data,
    input  logic [31:0] src1_data,
    input  logic [15:0] src0_count,
    input  logic [15:0] src1_count,
    input  logic        src0_eof,
    input  logic        src1_eof,
    output logic        src0_rden,
    output logic        src1_rden,
    input  logic        user_r_read_32_open,
    input  logic        user_r_read_32_rden,
    output logic [31:0] user_r_read_32_data,
    output logic        user_r_read_32_empty,
    output logic        user_r_read_32_eof,
    output logic [1:0]  dbg_state_o
);

    localparam logic [15:0] BURST_W = 16'(BURST);

    arb_state_e  state_q;
    logic [31:0] stg_q;
    logic        stg_valid_q;
    logic [31:0] rd_data_q;
    logic        last_q;
    logic        id_q;
    logic [15:0] remaining_q;

    logic [1:0]  req;
    logic [1:0]  gnt;
    logic [15:0] cnt_sel;
    logic [15:0] len_d;
    logic        host_rd;
    logic        fetch_go;

    assign req = {src1_count != 16'd0, src0_count != 16'd0};

    rd32_rr_pick2 u_pick (
        .req_i  (req),
        .last_i (last_q),
        .gnt_o  (gnt)
    );

    // Burst length is frozen at grant: min(count of the winner, BURST)
    always_comb begin
        cnt_sel = gnt[1] ? src1_count : src0_count;
        len_d   = (cnt_sel < BURST_W) ? cnt_sel : BURST_W;
    end

    assign host_rd = user_r_read_32_rden && stg_valid_q;

    // The source strobe is decoded from FETCH so the word lands during WAIT;
    // gating with open and async reset means no strobe escapes a close/reset.
    assign fetch_go  = user_r_read_32_open && (state_q == ST_FETCH) && !stg_valid_q;
    assign src0_rden = fetch_go && !id_q;
    assign src1_rden = fetch_go &&  id_q;

    assign user_r_read_32_data  = rd_data_q;
    assign user_r_read_32_empty = !stg_valid_q;
    assign user_r_read_32_eof   = src0_eof && src1_eof && (state_q == ST_IDLE) &&
                                  (src0_count == 16'd0) && (src1_count == 16'd0) &&
                                  !stg_valid_q;
    assign dbg_state_o = state_q;

    // Staging register, host data register and burst FSM
    always_ff @(posedge bus_clk or posedge bus_rst) begin
        if (bus_rst) begin
            state_q     <= ST_IDLE;
            stg_q       <= '0;
            stg_valid_q <= 1'b0;
            rd_data_q   <= '0;
            last_q      <= 1'b1;
            id_q        <= 1'b0;
            remaining_q <= '0;
        end else begin
            if (host_rd) begin
                rd_data_q   <= stg_q;
                stg_valid_q <= 1'b0;
            end
            if (!user_r_read_32_open) begin
                // Closing drops any staged or in-flight word; rr pointer is kept
                state_q     <= ST_IDLE;
                stg_valid_q <= 1'b0;
                remaining_q <= '0;
            end else begin
                // Loads only happen with stg empty, so they never collide with host_rd
                case (state_q)
                    ST_IDLE: begin
                        if (|req) begin
                            id_q        <= gnt[1];
                            last_q      <= gnt[1];
                            remaining_q <= len_d;
                            state_q     <= ST_HDR;
                        end
                    end
                    ST_HDR: begin
                        if (!stg_valid_q) begin
                            stg_q       <= make_hdr(HDR_MAGIC, id_q, remaining_q);
                            stg_valid_q <= 1'b1;
                            state_q     <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        if (!stg_valid_q) begin
                            state_q <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        stg_q       <= id_q ? src1_data : src0_data;
                        stg_valid_q <= 1'b1;
                        remaining_q <= remaining_q - 16'd1;
                        state_q     <= (remaining_q == 16'd1) ? ST_IDLE : ST_FETCH;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rd32_stream_arbiter.sv
// Bench for rd32_stream_arbiter: queue-backed source FIFOs, random host reads,
// expected host stream computed from the burst rules over queue snapshots.
module tb_rd32_stream_arbiter;

    localparam int         TB_BURST = 16;
    localparam logic [7:0] TB_MAGIC = 8'hA5;

    logic        bus_clk = 1'b0;
    logic        bus_rst = 1'b0;
    logic [31:0] src0_data = '0;
    logic [31:0] src1_data = '0;
    logic [15:0] src0_count = '0;
    logic [15:0] src1_count = '0;
    logic        src0_eof = 1'b0;
    logic        src1_eof = 1'b0;
    logic        src0_rden;
    logic        src1_rden;
    logic        user_r_read_32_open = 1'b0;
    logic        user_r_read_32_rden = 1'b0;
    logic [31:0] user_r_read_32_data;
    logic        user_r_read_32_empty;
    logic        user_r_read_32_eof;
    logic [1:0]  dbg_state;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] exp_q[$];
    int          mdl_last = 1;
    int          n_checks = 0;
    int          n_errors = 0;
    int          rden_cnt = 0;
    int          viol_cnt = 0;

    rd32_stream_arbiter #(.BURST(TB_BURST), .HDR_MAGIC(TB_MAGIC)) dut (
        .bus_clk              (bus_clk),
        .bus_rst              (bus_rst),
        .src0_data            (src0_data),
        .src1_data            (src1_data),
        .src0_count           (src0_count),
        .src1_count           (src1_count),
        .src0_eof             (src0_eof),
        .src1_eof             (src1_eof),
        .src0_rden            (src0_rden),
        .src1_rden            (src1_rden),
        .user_r_read_32_open  (user_r_read_32_open),
        .user_r_read_32_rden  (user_r_read_32_rden),
        .user_r_read_32_data  (user_r_read_32_data),
        .user_r_read_32_empty (user_r_read_32_empty),
        .user_r_read_32_eof   (user_r_read_32_eof),
        .dbg_state_o          (dbg_state)
    );

    // clock / reset
    always #5 bus_clk = ~bus_clk;

    task automatic do_reset();
        @(negedge bus_clk);
        bus_rst = 1'b1;
        repeat (2) @(posedge bus_clk);
        @(negedge bus_clk);
        bus_rst  = 1'b0;
        mdl_last = 1;
    endtask

    // source FIFO model: pop on rden, word visible the next cycle
    always @(posedge bus_clk) begin
        viol_cnt <= viol_cnt + int'(src0_rden && src1_rden)
                             + int'(src0_rden && q0.size() == 0)
                             + int'(src1_rden && q1.size() == 0);
        rden_cnt <= rden_cnt + int'(src0_rden) + int'(src1_rden);
        if (src0_rden && q0.size() != 0) src0_data <= q0.pop_front();
        if (src1_rden && q1.size() != 0) src1_data <= q1.pop_front();
        src0_count <= 16'(q0.size());
        src1_count <= 16'(q1.size());
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // reference: replay the burst rules over a snapshot of both source queues
    task automatic build_expected();
        logic [31:0] c0[$];
        logic [31:0] c1[$];
        int pick;
        int n;
        c0 = q0;
        c1 = q1;
        while (c0.size() > 0 || c1.size() > 0) begin
            if (c0.size() > 0 && c1.size() > 0) pick = (mdl_last == 1) ? 0 : 1;
            else if (c0.size() > 0)              pick = 0;
            else                                 pick = 1;
            n = (pick == 0) ? c0.size() : c1.size();
            if (n > TB_BURST) n = TB_BURST;
            exp_q.push_back({TB_MAGIC, 7'b0, 1'(pick), 16'(n)});
            for (int i = 0; i < n; i++) begin
                if (pick == 0) exp_q.push_back(c0.pop_front());
                else           exp_q.push_back(c1.pop_front());
            end
            mdl_last = pick;
        end
    endtask

    task automatic preload(input int n0, input int n1);
        for (int i = 0; i < n0; i++) q0.push_back($urandom());
        for (int i = 0; i < n1; i++) q1.push_back($urandom());
        repeat (2) @(posedge bus_clk);
    endtask

    // host driver + scoreboard; stops when exp_q drains or budget expires
    task automatic host_run(input int max_cycles, input int pct, input bit need_drain);
        logic        will;
        logic [31:0] last_data;
        logic [31:0] e;
        for (int c = 0; c < max_cycles && exp_q.size() > 0; c++) begin
            @(negedge bus_clk);
            last_data           = user_r_read_32_data;
            user_r_read_32_rden = ($urandom_range(99) < pct);
            will                = user_r_read_32_rden && !user_r_read_32_empty;
            @(posedge bus_clk);
            #1;
            if (will) begin
                e = exp_q.pop_front();
                check("host_word", user_r_read_32_data, e);
            end else if (user_r_read_32_rden) begin
                check("rden_empty_hold", user_r_read_32_data, last_data);
            end
        end
        @(negedge bus_clk);
        user_r_read_32_rden = 1'b0;
        if (need_drain) begin
            check("drain_left", 32'(exp_q.size()), 32'd0);
            repeat (4) @(posedge bus_clk);
            #1;
            check("drain_empty", 32'(user_r_read_32_empty), 32'd1);
        end
    endtask

    initial begin : main
        int          snap;
        logic [31:0] hold;
        bit          found;
        logic        will;
        logic [31:0] e;

        // reset state
        do_reset();
        #1;
        check("rst_empty", 32'(user_r_read_32_empty), 32'd1);
        check("rst_eof",   32'(user_r_read_32_eof),   32'd0);
        check("rst_data",  user_r_read_32_data,       32'd0);
        check("rst_rden",  {30'd0, src1_rden, src0_rden}, 32'd0);

        // single short burst from src0
        preload(3, 0);
        build_expected();
        user_r_read_32_open = 1'b1;
        host_run(200, 100, 1'b1);

        // host rden held while nothing is available
        snap = rden_cnt;
        hold = user_r_read_32_data;
        @(negedge bus_clk);
        user_r_read_32_rden = 1'b1;
        repeat (20) @(posedge bus_clk);
        #1;
        check("idle_rd_data", user_r_read_32_data, hold);
        check("idle_rd_rden", 32'(rden_cnt), 32'(snap));
        check("idle_rd_empty", 32'(user_r_read_32_empty), 32'd1);
        user_r_read_32_rden = 1'b0;

        // tied counts after reset: alternating bursts, src0 first
        user_r_read_32_open = 1'b0;
        do_reset();
        preload(40, 40);
        build_expected();
        check("tie_first_hdr", exp_q[0], 32'hA500_0010);
        user_r_read_32_open = 1'b1;
        host_run(2000, 100, 1'b1);

        // random fills and random host read rate; rr pointer carries over
        for (int r = 0; r < 4; r++) begin
            user_r_read_32_open = 1'b0;
            preload($urandom_range(45), $urandom_range(45));
            build_expected();
            user_r_read_32_open = 1'b1;
            host_run(4000, $urandom_range(100, 30), 1'b1);
        end

        // close during WAIT of a length-5 burst, then reopen
        user_r_read_32_open = 1'b0;
        preload(5, 0);
        exp_q.delete();
        build_expected();
        user_r_read_32_open = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge bus_clk);
            if (src0_rden) begin
                found = 1'b1;
                user_r_read_32_rden = 1'b0;
            end else begin
                user_r_read_32_rden = 1'b1;
                will = !user_r_read_32_empty;
                @(posedge bus_clk);
                #1;
                if (will) begin
                    e = exp_q.pop_front();
                    check("drop_hdr", user_r_read_32_data, e);
                end
            end
        end
        check("drop_fetch_seen", 32'(found), 32'd1);
        @(posedge bus_clk);
        #1;
        user_r_read_32_open = 1'b0;
        @(posedge bus_clk);
        #1;
        check("drop_empty", 32'(user_r_read_32_empty), 32'd1);
        snap = rden_cnt;
        repeat (6) @(posedge bus_clk);
        #1;
        check("drop_no_rden", 32'(rden_cnt), 32'(snap));
        check("drop_q0_left", 32'(q0.size()), 32'd4);
        exp_q.delete();
        build_expected();
        check("reopen_hdr", exp_q[0], 32'hA500_0004);
        user_r_read_32_open = 1'b1;
        host_run(500, 100, 1'b1);

        // reset in the middle of a src1 burst
        user_r_read_32_open = 1'b0;
        preload(0, 20);
        exp_q.delete();
        build_expected();
        user_r_read_32_open = 1'b1;
        host_run(8, 100, 1'b0);
        @(negedge bus_clk);
        bus_rst = 1'b1;
        user_r_read_32_open = 1'b0;
        #1;
        check("mrst_empty", 32'(user_r_read_32_empty), 32'd1);
        check("mrst_data",  user_r_read_32_data,       32'd0);
        check("mrst_eof",   32'(user_r_read_32_eof),   32'd0);
        check("mrst_rden",  {30'd0, src1_rden, src0_rden}, 32'd0);
        @(negedge bus_clk);
        bus_rst  = 1'b0;
        mdl_last = 1;
        snap = rden_cnt;
        repeat (10) @(posedge bus_clk);
        #1;
        check("mrst_no_rden", 32'(rden_cnt), 32'(snap));
        exp_q.delete();
        build_expected();
        user_r_read_32_open = 1'b1;
        host_run(1000, 80, 1'b1);

        // end of stream reporting
        user_r_read_32_open = 1'b0;
        src0_eof = 1'b1;
        src1_eof = 1'b1;
        repeat (2) @(posedge bus_clk);
        #1;
        check("eof_set", 32'(user_r_read_32_eof), 32'd1);
        @(negedge bus_clk);
        q0.push_back($urandom());
        repeat (2) @(posedge bus_clk);
        #1;
        check("eof_count_nz", 32'(user_r_read_32_eof), 32'd0);
        @(negedge bus_clk);
        q0.delete();
        src1_eof = 1'b0;
        repeat (2) @(posedge bus_clk);
        #1;
        check("eof_one_src", 32'(user_r_read_32_eof), 32'd0);
        @(negedge bus_clk);
        src1_eof = 1'b1;
        repeat (2) @(posedge bus_clk);
        #1;
        check("eof_again", 32'(user_r_read_32_eof), 32'd1);

        check("rden_violations", 32'(viol_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // hard time limit so the run always terminates
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
